sieve_rd_arbiter: RTL and testbench

Shares the single read port (port B) of the sieve bitmap RAM between two requesters: port 0 is the sieve engine, which checks whether `i` is still unmarked, and port 1 is the prime scanner that walks up or down for display. It grants one read per cycle and pipelines the addresses into the RAM. It returns each bit to its owner after a fixed latency. It snoops the RAM write port so that a returned bit never misses a mark written while that read was in flight.

---
 rtl/sieve_pkg.sv | 22 ++
 rtl/sieve_rd_arbiter_if.sv | 36 +++
 rtl/rr_arb2.sv | 50 +++++
 rtl/sieve_rd_arbiter.sv | 107 ++++++++++
 tb/tb_sieve_rd_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/sieve_pkg.sv
// sieve_pkg: shared constants and types for the sieve bitmap datapath.
//   SIEVE_AW      address width of the sieve bitmap RAM
//   SIEVE_N       largest number covered by the sieve
//   SIEVE_RD_LAT  read latency of the bitmap RAM port B
//   sieve_addr_t  bit address into the bitmap
//   rd_slot_t     one in-flight read: {valid, owner tag, address, snooped hit}
package sieve_pkg;

  localparam int SIEVE_AW     = 20;
  localparam int SIEVE_N      = 999999;
  localparam int SIEVE_RD_LAT = 2;

  typedef logic [SIEVE_AW-1:0] sieve_addr_t;

  typedef struct packed {
    logic        valid;
    logic        tag;
    sieve_addr_t addr;
    logic        hit;
  } rd_slot_t;

endpackage

// File: rtl/sieve_rd_arbiter_if.sv
// sieve_rd_arbiter_if: the two requester channels of the bitmap read arbiter.
//   reqN_valid/reqN_addr  request from port N (0 = sieve engine, 1 = scanner)
//   reqN_ready            grant for port N, combinational, this cycle
//   rspN_valid/rspN_data  one-cycle response pulse carrying the sieve bit
// modport master: requester side; modport slave: arbiter side.
interface sieve_rd_arbiter_if
  import sieve_pkg::*;
#(
  parameter int AW = SIEVE_AW
);

  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic          req0_ready;
  logic          rsp0_valid;
  logic          rsp0_data;

  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic          req1_ready;
  logic          rsp1_valid;
  logic          rsp1_data;

  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way grant logic for the bitmap read port.
//   clk, rstn_signal  clock and async active-low reset (round-robin build only)
//   req[1:0]          per-port request, already qualified by reset
//   gnt[1:0]          one-hot (or zero) grant, never set without its request
// Build option SIEVE_ARB_FIXED_PRIO_EN: port 0 always wins and no grant
// history is kept. Otherwise round-robin on the last_gnt register, which
// resets to 1 so that port 0 wins the first contention.
module rr_arb2 (
`ifndef SIEVE_ARB_FIXED_PRIO_EN
  input  logic       clk,
  input  logic       rstn_signal,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef SIEVE_ARB_FIXED_PRIO_EN

  always_comb begin
    gnt[0] = req[0];
    gnt[1] = req[1] & ~req[0];
  end

`else

  logic last_gnt;

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_signal) begin
    if (!rstn_signal) begin
      last_gnt <= 1'b1;
    end else if (|gnt) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      last_gnt <= gnt[1];
    end
  end

`endif

endmodule

// File: rtl/sieve_rd_arbiter.sv
// sieve_rd_arbiter: shares bitmap RAM read port B between the sieve engine
// (port 0) and the prime scanner (port 1). One grant per cycle, the address
// is registered into the RAM, and each bit returns to its owner RD_LAT+1
// edges after accept. Writes on RAM port A are snooped so a returned bit
// also reflects any mark written while the read was in flight (marks only
// ever set bits, so OR-ing is exact).
//   clk, rstn_signal    clock, async active-low reset
//   rd                  requester channels (sieve_rd_arbiter_if.slave)
//   ram_addrb           registered RAM read address
//   ram_doutb           RAM read data, valid RD_LAT cycles after ram_addrb
//   wr_en/wr_addr/wr_data  snoop of RAM port A
//   busy                at least one read in flight
// Parameters: AW must match the interface AW; RD_LAT legal range 1..4.
// Build option SIEVE_ARB_FIXED_PRIO_EN selects fixed priority in rr_arb2.
module sieve_rd_arbiter
  import sieve_pkg::*;
#(
  parameter int AW     = SIEVE_AW,
  parameter int RD_LAT = SIEVE_RD_LAT
) (
  input  logic              clk,
  input  logic              rstn_signal,
  sieve_rd_arbiter_if.slave rd,
  output logic [AW-1:0]     ram_addrb,
  input  logic              ram_doutb,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic              wr_data,
  output logic              busy
);

  // Same layout as rd_slot_t, but sized by the AW parameter.
  typedef struct packed {
    logic          valid;
    logic          tag;
    logic [AW-1:0] addr;
    logic          hit;
  } slot_t;

  localparam int LAST = RD_LAT;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       accept;
  slot_t      new_slot;
  slot_t      pipe [LAST+1];
  slot_t      aged [LAST+1];

  // Grants are suppressed while reset is asserted, whatever the valids.
  assign req    = {rd.req1_valid, rd.req0_valid} & {2{rstn_signal}};
  assign accept = |gnt;

  assign rd.req0_ready = gnt[0];
  assign rd.req1_ready = gnt[1];

  rr_arb2 u_arb (
`ifndef SIEVE_ARB_FIXED_PRIO_EN
    .clk         (clk),
    .rstn_signal (rstn_signal),
`endif
    .req         (req),
    .gnt         (gnt)
  );

  // Slot entering the pipe; a write landing on the accept edge counts.
  always_comb begin
    new_slot = '0;
    if (accept) begin
      new_slot.valid = 1'b1;
      new_slot.tag   = gnt[1];
      new_slot.addr  = gnt[1] ? rd.req1_addr : rd.req0_addr;
      new_slot.hit   = wr_en & wr_data & (wr_addr == new_slot.addr);
    end
  end

  // Every in-flight slot picks up a matching mark on each edge it sees.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= LAST; k++) begin
      aged[k]     = pipe[k];
      aged[k].hit = pipe[k].hit | (wr_en & wr_data & (wr_addr == pipe[k].addr));
      busy        = busy | pipe[k].valid;
    end
  end

  always_ff @(posedge clk or negedge rstn_signal) begin
    if (!rstn_signal) begin
      // NOTE: the slot array is a handful of flops and must drop in-flight reads on reset, so it is cleared, unlike a RAM.
      for (int k = 0; k <= LAST; k++) pipe[k] <= '0;
      ram_addrb     <= '0;
      rd.rsp0_valid <= 1'b0;
      rd.rsp0_data  <= 1'b0;
      rd.rsp1_valid <= 1'b0;
      rd.rsp1_data  <= 1'b0;
    end else begin
      pipe[0] <= new_slot;
      for (int k = 1; k <= LAST; k++) pipe[k] <= aged[k-1];
      if (accept) ram_addrb <= new_slot.addr;
      // The slot leaving the pipe meets its RAM data on this edge.
      rd.rsp0_valid <= aged[LAST].valid & ~aged[LAST].tag;
      rd.rsp0_data  <= aged[LAST].valid & ~aged[LAST].tag & (ram_doutb | aged[LAST].hit);
      rd.rsp1_valid <= aged[LAST].valid &  aged[LAST].tag;
      rd.rsp1_data  <= aged[LAST].valid &  aged[LAST].tag & (ram_doutb | aged[LAST].hit);
    end
  end

endmodule

// File: tb/tb_sieve_rd_arbiter.sv
// tb_sieve_rd_arbiter: scoreboard bench for sieve_rd_arbiter with a
// behavioural 2-cycle bitmap RAM. Stimulus pushes the hand-computed
// response expected for each grant; a monitor pops on every response pulse.
`timescale 1ns/1ps
module tb_sieve_rd_arbiter;
  import sieve_pkg::*;

  localparam int AW     = SIEVE_AW;
  localparam int RD_LAT = 2;

  typedef struct {
    int   port;
    logic data;
    int   cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn_signal = 1'b0;
  logic [AW-1:0] ram_addrb;
  logic          ram_doutb;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_data = 1'b0;
  logic          busy;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];

  sieve_rd_arbiter_if #(.AW(AW)) rd_if ();

  sieve_rd_arbiter #(.AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rstn_signal (rstn_signal),
    .rd          (rd_if),
    .ram_addrb   (ram_addrb),
    .ram_doutb   (ram_doutb),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bitmap RAM: low 8 address bits, read-before-write, RD_LAT = 2.
  logic mem [256] = '{default: 1'b0};
  logic d1 = 1'b0;
  logic d2 = 1'b0;
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr[7:0]] <= wr_data;
    d1 <= mem[ram_addrb[7:0]];
    d2 <= d1;
  end
  assign ram_doutb = d2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus: exp_gnt is -1 (none), 0 or 1.
  task automatic step(input logic v0, input int a0, input logic v1, input int a1,
                      input int exp_gnt, input logic exp_d,
                      input logic we = 1'b0, input int wa = 0);
    exp_t e;
    @(negedge clk);
    rd_if.req0_valid = v0;
    rd_if.req0_addr  = AW'(a0);
    rd_if.req1_valid = v1;
    rd_if.req1_addr  = AW'(a1);
    wr_en   = we;
    wr_addr = AW'(wa);
    wr_data = we;
    #1;
    check("req0_ready", 32'(rd_if.req0_ready), 32'(exp_gnt == 0));
    check("req1_ready", 32'(rd_if.req1_ready), 32'(exp_gnt == 1));
    if (exp_gnt >= 0) begin
      e.port = exp_gnt;
      e.data = exp_d;
      e.cyc  = cyc + RD_LAT + 2;
      sb.push_back(e);
    end
  endtask

  // Monitor: every response must match the oldest expectation, on time.
  always @(negedge clk) begin
    exp_t e;
    if (rstn_signal) begin
      if (sb.size() != 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        check("rsp_missing", 32'(cyc), 32'(e.cyc));
      end
      if (rd_if.rsp0_valid && rd_if.rsp1_valid) begin
        check("rsp_both_valid", 32'd1, 32'd0);
      end else if (rd_if.rsp0_valid || rd_if.rsp1_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rd_if.rsp1_valid), 32'd2);
        end else begin
          e = sb.pop_front();
          check("rsp_port", 32'(rd_if.rsp1_valid), 32'(e.port));
          check("rsp_data", 32'(rd_if.rsp1_valid ? rd_if.rsp1_data : rd_if.rsp0_data), 32'(e.data));
          check("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    int b2b_exp [10] = '{0, 0, 1, 0, 1, 0, 1, 1, 1, 0};
    int marks [5] = '{4, 6, 8, 9, 10};

    // Reset values, with both valids high.
    rd_if.req0_valid = 1'b1;
    rd_if.req0_addr  = AW'(3);
    rd_if.req1_valid = 1'b1;
    rd_if.req1_addr  = AW'(5);
    #12;
    check("rst_req0_ready", 32'(rd_if.req0_ready), 32'd0);
    check("rst_req1_ready", 32'(rd_if.req1_ready), 32'd0);
    check("rst_rsp0_valid", 32'(rd_if.rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rd_if.rsp1_valid), 32'd0);
    check("rst_rsp0_data",  32'(rd_if.rsp0_data),  32'd0);
    check("rst_rsp1_data",  32'(rd_if.rsp1_data),  32'd0);
    check("rst_ram_addrb",  32'(ram_addrb),        32'd0);
    check("rst_busy",       32'(busy),             32'd0);
    @(negedge clk);
    rd_if.req0_valid = 1'b0;
    rd_if.req1_valid = 1'b0;
    rstn_signal = 1'b1;

    // Contention on addrs 11 / 13 (both clear), then port 1 alone.
`ifdef SIEVE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) step(1, 11, 1, 13, 0, 0);
`else
    for (int i = 0; i < 4; i++) step(1, 11, 1, 13, i % 2, 0);
`endif
    step(0, 11, 1, 13, 1, 0);

    // Mark 4, 6, 8, 9, 10, then port 1 streams addrs 2..11 back to back.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, -1, 0, 1, marks[i]);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 2 + i, 1, b2b_exp[i][0]);
    step(0, 0, 0, 0, -1, 0);

    // Single read of a marked bit.
    step(0, 0, 0, 0, -1, 0, 1, 7);
    step(1, 7, 0, 0, 0, 1);

    // Snoop: write one edge after accept, on the accept edge, on the
    // response edge (all reflected) and one edge too late (not reflected).
    step(1, 25, 0, 0, 0, 1);
    step(0, 0, 0, 0, -1, 0, 1, 25);
    step(1, 27, 0, 0, 0, 1, 1, 27);
    step(1, 29, 0, 0, 0, 1);
    step(0, 0, 0, 0, -1, 0);
    step(0, 0, 0, 0, -1, 0);
    step(0, 0, 0, 0, -1, 0, 1, 29);
    step(1, 31, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, -1, 0);
    step(0, 0, 0, 0, -1, 0, 1, 31);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, -1, 0);

    // Reset mid-flight: three port 0 reads, then reset before the first returns.
    step(1, 4, 0, 0, 0, 1);
    step(1, 6, 0, 0, 0, 1);
    step(1, 8, 0, 0, 0, 1);
    @(negedge clk);
    check("busy_inflight", 32'(busy), 32'd1);
    rd_if.req0_valid = 1'b0;
    rstn_signal = 1'b0;
    sb.delete();
    #1;
    check("midrst_busy",       32'(busy),             32'd0);
    check("midrst_rsp0_valid", 32'(rd_if.rsp0_valid), 32'd0);
    check("midrst_ram_addrb",  32'(ram_addrb),        32'd0);
    @(negedge clk);
    rstn_signal = 1'b1;
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, -1, 0);
    step(1, 11, 1, 13, 0, 0);
    step(0, 0, 0, 0, -1, 0);

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
